hm2reg_master: RTL
==================

# hm2reg_master

Avalon-MM master bridge: the initiator-side counterpart of the hm2reg register slave. It accepts single-word read/write commands from custom con logic and issues them on an Avalon-MM master port, honouring waitrequest and pipelined readdatavalid. It enforces a per-transaction timeout and discards late read responses. It also converts a slave-side interrupt into the active-low con interrupt convention.

## Interface
- ADDRESS_WIDTH, 14, address width
- DATA_WIDTH, 32, data word width
- TIMEOUT, 255, cycles a transaction may stay outstanding before abort; range 1..2^TO_WIDTH-1
- TO_WIDTH, 8, timeout counter width
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- master_address  out  ADDRESS_WIDTH  Avalon address
- master_read  out  1  Avalon read request
- master_write  out  1  Avalon write request
- master_writedata  out  DATA_WIDTH  Avalon write data
- master_readdata  in  DATA_WIDTH  Avalon read data
- master_waitrequest  in  1  slave stall
- master_readdatavalid  in  1  read data valid
- master_irq  in  1  slave interrupt, active-high, asynchronous to clk
- con_adrin  in  ADDRESS_WIDTH  command address
- con_datain  in  DATA_WIDTH  command write data
- con_write_in  in  1  write command strobe
- con_read_in  in  1  read command strobe
- con_dataout  out  DATA_WIDTH  read result, registered
- con_valid  out  1  one-cycle pulse: con_dataout updated
- con_error  out  1  one-cycle pulse: transaction timed out
- con_busy  out  1  command not accepted while high
- con_int_out  out  1  interrupt to con logic, active-low

## Operation
- States: IDLE, WR, RD, RDWAIT. con_busy = (state != IDLE), decoded from the state register.
- IDLE: a command is accepted on any edge where con_write_in or con_read_in is high. Both high: the write is accepted and the read is dropped. Accept latches con_adrin into master_address and con_datain into master_writedata, clears the timeout counter, then enters WR or RD.
- WR: master_write=1 held with stable address/data. On the first cycle with master_waitrequest=0, go to IDLE.
- RD: master_read=1 held. On the first cycle with master_waitrequest=0, go to RDWAIT.
- RDWAIT: on master_readdatavalid=1 while drop_cnt==0: con_dataout <= master_readdata, con_valid pulses, go to IDLE.
- Timeout: the counter increments every cycle in WR/RD/RDWAIT. When it reaches TIMEOUT, the transaction aborts:
  - master_read/master_write are deasserted.
  - con_error pulses.
  - Read abort also sets con_dataout <= all ones and pulses con_valid together with con_error.
  - Abort from RDWAIT increments drop_cnt.
  - State returns to IDLE.
- Stale responses: drop_cnt is a 4-bit saturating counter. Any readdatavalid while drop_cnt>0 (any state) is discarded and decrements drop_cnt. readdatavalid in IDLE/WR/RD with drop_cnt==0 is discarded silently.
- A readdatavalid in the same cycle as the RD accept is ignored; data is expected no earlier than the following cycle.
- IRQ: master_irq passes through a 2-flop synchronizer; con_int_out = ~sync2.
- Reset (asynchronous, any state, including mid-transaction):
  - state IDLE, master_read/master_write 0, master_address/master_writedata 0
  - con_dataout 0, con_valid 0, con_error 0, drop_cnt 0, timeout counter 0
  - synchronizer flops 0, so con_int_out=1
  - An in-flight Avalon read is abandoned without a drop_cnt entry.

## Timing
- Write, no stall: command at edge N → master_write high in cycle N+1 → IDLE at edge N+2; con_busy high for exactly 1 cycle.
- Each waitrequest cycle adds 1 cycle.
- Read: master_read high from N+1. With readdatavalid L cycles after the accept cycle, con_valid and con_dataout appear 1 cycle after readdatavalid; con_busy falls in the same cycle con_valid rises.
- Back-to-back commands: the next command is accepted at the first edge where con_busy=0.
- The timeout abort takes effect at the edge where the counter equals TIMEOUT; outputs change the following cycle.
- IRQ latency: 2–3 clk cycles from master_irq edge to con_int_out.

## Test plan
- Write 0x12345678 to 0x0A5, waitrequest high 2 cycles → master_write high 3 cycles with stable address/data, con_busy high 3 cycles, no con_valid/con_error.
- Read 0x010, waitrequest 0, readdatavalid 3 cycles later with 0xDEADBEEF → con_dataout=0xDEADBEEF, con_valid single pulse, con_busy low in the same cycle.
- TIMEOUT=8 read with no readdatavalid → con_error and con_valid pulse, con_dataout=0xFFFFFFFF, drop_cnt=1. Late readdatavalid 0x11111111 is discarded. Next read returns 0x22222222 correctly.
- con_read_in and con_write_in high together → only a write is issued; no master_read ever asserted.
- reset_n low during RDWAIT → all outputs at reset values immediately (asynchronous), con_busy 0. A following read completes normally.
- master_irq pulse of 5 cycles → con_int_out low for 5 cycles, starting 2–3 cycles after the master_irq rising edge. con_int_out=1 after reset.

Source files
------------

// File: rtl/hm2reg_master_if.sv
// rtl/hm2reg_master_if.sv - Avalon-MM master-side bus bundle for hm2reg_master
interface hm2reg_master_if #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] master_address;
  logic                     master_read;
  logic                     master_write;
  logic [DATA_WIDTH-1:0]    master_writedata;
  logic [DATA_WIDTH-1:0]    master_readdata;
  logic                     master_waitrequest;
  logic                     master_readdatavalid;
  logic                     master_irq;

  modport master (
    output master_address, master_read, master_write, master_writedata,
    input  master_readdata, master_waitrequest, master_readdatavalid, master_irq
  );

  modport slave (
    input  master_address, master_read, master_write, master_writedata,
    output master_readdata, master_waitrequest, master_readdatavalid, master_irq
  );
endinterface

// File: rtl/hm2reg_master.sv
// rtl/hm2reg_master.sv - Avalon-MM master bridge with timeout, stale-read drop and irq sync
module hm2reg_master #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 255,
  parameter int TO_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  hm2reg_master_if.master          av,
  input  logic [ADDRESS_WIDTH-1:0] con_adrin,
  input  logic [DATA_WIDTH-1:0]    con_datain,
  input  logic                     con_write_in,
  input  logic                     con_read_in,
  output logic [DATA_WIDTH-1:0]    con_dataout,
  output logic                     con_valid,
  output logic                     con_error,
  output logic                     con_busy,
  output logic                     con_int_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WR     = 2'd1;
  localparam logic [1:0] S_RD     = 2'd2;
  localparam logic [1:0] S_RDWAIT = 2'd3;

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT);

  logic [1:0]               r_state;
  logic [TO_WIDTH-1:0]      r_to_cnt;
  logic [3:0]               r_drop_cnt;
  logic                     r_read;
  logic                     r_write;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0]    r_writedata;
  logic [DATA_WIDTH-1:0]    r_dataout;
  logic                     r_valid;
  logic                     r_error;
  logic                     r_irq_s1;
  logic                     r_irq_s2;

  logic w_timeout;
  logic w_stale;
  logic w_rd_done;
  logic w_drop_inc;

  assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == TO_LIMIT);
  assign w_stale   = av.master_readdatavalid && (r_drop_cnt != 4'd0);
  assign w_rd_done = (r_state == S_RDWAIT) && av.master_readdatavalid && (r_drop_cnt == 4'd0);

  // A read the slave already accepted still owes a response after an abort, so it must be dropped later.
  assign w_drop_inc = w_timeout && !w_rd_done &&
                      ((r_state == S_RDWAIT) || ((r_state == S_RD) && !av.master_waitrequest));

  // Command FSM: accept, Avalon handshake, read return and timeout abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_to_cnt    <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_address   <= '0;
      r_writedata <= '0;
      r_dataout   <= '0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      if (r_state == S_IDLE) begin
        if (con_write_in || con_read_in) begin
          r_address   <= con_adrin;
          r_writedata <= con_datain;
          r_to_cnt    <= '0;
          if (con_write_in) begin
            r_write <= 1'b1;
            r_state <= S_WR;
          end else begin
            r_read  <= 1'b1;
            r_state <= S_RD;
          end
        end
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
        if ((r_state == S_WR) && !av.master_waitrequest) begin
          r_write <= 1'b0;
          r_state <= S_IDLE;
        end else if (w_rd_done) begin
          r_dataout <= av.master_readdata;
          r_valid   <= 1'b1;
          r_state   <= S_IDLE;
        end else if (w_timeout) begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_error <= 1'b1;
          if (r_state != S_WR) begin
            r_dataout <= '1;
            r_valid   <= 1'b1;
          end
          r_state <= S_IDLE;
        end else if ((r_state == S_RD) && !av.master_waitrequest) begin
          r_read  <= 1'b0;
          r_state <= S_RDWAIT;
        end
      end
    end
  end

  // Saturating count of read responses still owed by the slave for aborted reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= 4'd0;
    end else if (w_drop_inc && !w_stale) begin
      if (r_drop_cnt != 4'hF) begin
        r_drop_cnt <= r_drop_cnt + 4'd1;
      end
    end else if (!w_drop_inc && w_stale) begin
      r_drop_cnt <= r_drop_cnt - 4'd1;
    end
  end

  // Two-flop synchronizer for the asynchronous slave interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_s1 <= 1'b0;
      r_irq_s2 <= 1'b0;
    end else begin
      r_irq_s1 <= av.master_irq;
      r_irq_s2 <= r_irq_s1;
    end
  end

  assign av.master_address   = r_address;
  assign av.master_read      = r_read;
  assign av.master_write     = r_write;
  assign av.master_writedata = r_writedata;
  assign con_dataout         = r_dataout;
  assign con_valid           = r_valid;
  assign con_error           = r_error;
  assign con_busy            = (r_state != S_IDLE);
  assign con_int_out         = ~r_irq_s2;

endmodule
